box_reduce: RTL

Parametrised 2x2 box reducer for the camera pixel pipeline, sitting between the Bayer/RGB converter and the frame-store writer. It accepts a single raster-order pixel stream with a valid strobe and keeps the previous row in an internal line buffer. Per channel it produces the average, maximum, minimum or passthrough of each 2x2 window, either decimated (one output per 2x2 block) or sliding (one output per pixel after the first row and column).

---
 rtl/box_pkg.sv | 42 ++++
 rtl/box_line_buf.sv | 46 ++++
 rtl/box_reduce.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/box_pkg.sv
// box_pkg: shared types and the per-channel 2x2 reduction used by box_reduce.
// Arithmetic runs at a fixed maximum channel width; callers zero-extend and truncate.
package box_pkg;

  typedef enum logic [1:0] {
    AVG     = 2'b00,
    MAX     = 2'b01,
    PIX_MIN = 2'b10,
    PASS    = 2'b11
  } mode_e;

  localparam int PIX_W_MAX = 16;
  localparam int SUM_W     = PIX_W_MAX + 2;

  // ul/ur are the row above (older, newer), bl/br the current row; br is the newest pixel.
  function automatic logic [PIX_W_MAX-1:0] reduce4(
    input mode_e                m,
    input logic                 round,
    input logic [PIX_W_MAX-1:0] ul,
    input logic [PIX_W_MAX-1:0] ur,
    input logic [PIX_W_MAX-1:0] bl,
    input logic [PIX_W_MAX-1:0] br
  );
    logic [SUM_W-1:0]     sum;
    logic [PIX_W_MAX-1:0] hi_top, hi_bot, lo_top, lo_bot, res;
    sum = SUM_W'(ul) + SUM_W'(ur) + SUM_W'(bl) + SUM_W'(br)
        + (round ? SUM_W'(2'd2) : SUM_W'(2'd0));
    hi_top = (ul > ur) ? ul : ur;
    hi_bot = (bl > br) ? bl : br;
    lo_top = (ul < ur) ? ul : ur;
    lo_bot = (bl < br) ? bl : br;
    case (m)
      AVG:     res = PIX_W_MAX'(sum >> 2'd2);
      MAX:     res = (hi_top > hi_bot) ? hi_top : hi_bot;
      PIX_MIN: res = (lo_top < lo_bot) ? lo_top : lo_bot;
      PASS:    res = br;
      default: res = br;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/box_line_buf.sv
// box_line_buf: one-line pixel store, single port, read-before-write with a registered read.
// Array contents are deliberately left uninitialised; only the read register resets.
module box_line_buf import box_pkg::*; #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 12,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  // Read returns the value stored before this cycle's write, held across idle cycles.
  always_comb begin
    if (en) begin
      rd_data_d = mem_q[addr];
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Storage array, written on every accepted pixel.
  always_ff @(posedge clk) begin
    if (en) begin
      mem_q[addr] <= wr_data;
    end
  end

  // Read data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/box_reduce.sv
// box_reduce: 2x2 window reducer over a raster pixel stream (AVG/MAX/MIN/PASS per channel).
// Pipeline: pixel accepted -> window registers + line-buffer read -> registered result.
module box_reduce import box_pkg::*; #(
  parameter int PIX_W    = 12,
  parameter int CHANNELS = 1,
  parameter int LINE_W   = 640,
  parameter int DECIMATE = 1,
  parameter int ROUND    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                mode,
  input  logic                      in_valid,
  input  logic                      in_sof,
  input  logic [CHANNELS*PIX_W-1:0] in_data,
  output logic                      out_valid,
  output logic                      out_sof,
  output logic [CHANNELS*PIX_W-1:0] out_data
);

  localparam int            DW       = CHANNELS * PIX_W;
  localparam int            CW       = $clog2(LINE_W);
  localparam logic [CW-1:0] COL_LAST = CW'(LINE_W - 1);

  logic [CW-1:0] col_q, col_d, col_eff;
  logic          row_odd_q, row_odd_d, row_odd_eff;
  logic          first_row_q, first_row_d, first_row_eff;
  mode_e         frame_mode_q, frame_mode_d, win_mode_q, win_mode_d;
  logic          sof_pend_q, sof_pend_d, sof_px, emit;
  logic [DW-1:0] cur_q, cur_d, cur_prev_q, cur_prev_d, up_prev_q, up_prev_d, up_s;
  logic          win_valid_q, win_valid_d, win_sof_q, win_sof_d;
  logic          out_valid_q, out_valid_d, out_sof_q, out_sof_d;
  logic [DW-1:0] out_data_q, out_data_d, result_s;

  box_line_buf #(.DEPTH(LINE_W), .WIDTH(DW), .AW(CW)) u_line_buf (
    .clk     (clk),
    .rst     (rst),
    .en      (in_valid),
    .addr    (col_eff),
    .wr_data (in_data),
    .rd_data (up_s)
  );

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    assign result_s[ch*PIX_W +: PIX_W] = PIX_W'(reduce4(
      win_mode_q, ROUND != 0,
      PIX_W_MAX'(up_prev_q[ch*PIX_W +: PIX_W]), PIX_W_MAX'(up_s[ch*PIX_W +: PIX_W]),
      PIX_W_MAX'(cur_prev_q[ch*PIX_W +: PIX_W]), PIX_W_MAX'(cur_q[ch*PIX_W +: PIX_W])));
  end

  // Next-state for counters, window registers and the result pipeline.
  always_comb begin
    sof_px = in_valid & in_sof;
    // A start-of-frame pixel overrides the counters for itself, including at line end.
    if (sof_px) begin
      col_eff       = '0;
      row_odd_eff   = 1'b0;
      first_row_eff = 1'b1;
      frame_mode_d  = mode_e'(mode);
    end else begin
      col_eff       = col_q;
      row_odd_eff   = row_odd_q;
      first_row_eff = first_row_q;
      frame_mode_d  = frame_mode_q;
    end

    emit = in_valid & ~first_row_eff & (col_eff != '0)
         & ((DECIMATE == 0) | (col_eff[0] & row_odd_eff));

    if (!in_valid) begin
      col_d       = col_q;
      row_odd_d   = row_odd_q;
      first_row_d = first_row_q;
      cur_d       = cur_q;
      cur_prev_d  = cur_prev_q;
      up_prev_d   = up_prev_q;
    end else begin
      if (col_eff == COL_LAST) begin
        col_d       = '0;
        row_odd_d   = ~row_odd_eff;
        first_row_d = 1'b0;
      end else begin
        col_d       = col_eff + CW'(1'b1);
        row_odd_d   = row_odd_eff;
        first_row_d = first_row_eff;
      end
      cur_d      = in_data;
      cur_prev_d = cur_q;
      up_prev_d  = up_s;
    end

    if (sof_px) begin
      sof_pend_d = 1'b1;
    end else if (emit) begin
      sof_pend_d = 1'b0;
    end else begin
      sof_pend_d = sof_pend_q;
    end

    win_valid_d = emit;
    win_sof_d   = emit & sof_pend_q;
    win_mode_d  = frame_mode_d;
    out_valid_d = win_valid_q;
    out_sof_d   = win_sof_q;
    if (win_valid_q) begin
      out_data_d = result_s;
    end else begin
      out_data_d = out_data_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_odd_q    <= 1'b0;
      first_row_q  <= 1'b1;
      frame_mode_q <= AVG;
      sof_pend_q   <= 1'b0;
      cur_q        <= '0;
      cur_prev_q   <= '0;
      up_prev_q    <= '0;
      win_valid_q  <= 1'b0;
      win_sof_q    <= 1'b0;
      win_mode_q   <= AVG;
      out_valid_q  <= 1'b0;
      out_sof_q    <= 1'b0;
      out_data_q   <= '0;
    end else begin
      col_q        <= col_d;
      row_odd_q    <= row_odd_d;
      first_row_q  <= first_row_d;
      frame_mode_q <= frame_mode_d;
      sof_pend_q   <= sof_pend_d;
      cur_q        <= cur_d;
      cur_prev_q   <= cur_prev_d;
      up_prev_q    <= up_prev_d;
      win_valid_q  <= win_valid_d;
      win_sof_q    <= win_sof_d;
      win_mode_q   <= win_mode_d;
      out_valid_q  <= out_valid_d;
      out_sof_q    <= out_sof_d;
      out_data_q   <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_data  = out_data_q;

endmodule
